// File: rtl/fir_output_decimator_pkg.sv
// fir_output_decimator_pkg: width defaults and sizing helpers shared by the
// FIR output stage, so the filter, decimator and FIFO agree on word sizes.
package fir_output_decimator_pkg;

  localparam int DEF_DATA_IN_W    = 15;
  localparam int DEF_DATA_OUT_W   = 8;
  localparam int DEF_SHIFT        = 7;
  localparam int DEF_DEC_FACTOR   = 2;
  localparam int DEF_PRIME_CYCLES = 2;
  localparam int DEF_FIFO_DEPTH   = 4;

  // FIFO operation for one cycle, encoded as {push_accepted, pop_accepted}.
  typedef enum logic [1:0] {
    FIFO_HOLD = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Number of bits needed to hold the values 0..value, never less than one.
  function automatic int bits_for(input int value);
    int width;
    width = clog2(value + 1);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// fir_out_fifo: synchronous first-word-fall-through FIFO for scaled FIR words.
// The head word is presented combinationally on rd_data whenever the FIFO holds
// data; an empty FIFO reads as zero. A push arriving while full is accepted only
// if a pop happens in the same cycle; otherwise it is ignored here and the
// caller decides what to do about the lost word.
module fir_out_fifo
  import fir_output_decimator_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = DEF_DATA_OUT_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  fifo_op_e         op;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Qualify the requests: popping an empty FIFO is a no-op, and a full FIFO
  // only takes a new word when the head is leaving in the same cycle.
  always_comb begin
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    op      = fifo_op_e'({push_ok, pop_ok});
  end

  // Pointers wrap naturally because DEPTH is a power of two; the occupancy
  // count is kept separately so full and empty are unambiguous.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (op)
        FIFO_PUSH: begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
        end
        FIFO_POP: begin
          rd_ptr <= rd_ptr + 1'b1;
          count  <= count - 1'b1;
        end
        FIFO_BOTH: begin
          wr_ptr <= wr_ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

  // Storage has no reset: stale words are unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/fir_output_decimator.sv
// fir_output_decimator: tail stage of the pipelined FIR. Drops the samples that
// come out while the filter pipeline is still filling, keeps one of every
// DEC_FACTOR samples after that, scales each kept word down by SHIFT bits with
// saturation to DATA_OUT_W bits, and queues the result in a small FWFT FIFO
// with a valid/ready handshake toward the consumer.
// Build option: define FIR_DEC_ROUND_EN for round-half-up scaling; leave it
// undefined for plain truncation. Saturation is always applied.
module fir_output_decimator
  import fir_output_decimator_pkg::*;
#(
  parameter int DATA_IN_W    = DEF_DATA_IN_W,
  parameter int DATA_OUT_W   = DEF_DATA_OUT_W,
  parameter int SHIFT        = DEF_SHIFT,
  parameter int DEC_FACTOR   = DEF_DEC_FACTOR,
  parameter int PRIME_CYCLES = DEF_PRIME_CYCLES,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DATA_IN_W-1:0]        FIR_in,
  input  logic                        in_valid,
  output logic [DATA_OUT_W-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                        overflow
);

  localparam int PRIME_W = bits_for(PRIME_CYCLES);
  localparam int DEC_W   = bits_for(DEC_FACTOR - 1);
  localparam int SUM_W   = DATA_IN_W + 1;

  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(PRIME_CYCLES);
  localparam logic [DEC_W-1:0]   DEC_LAST   = DEC_W'(DEC_FACTOR - 1);
  localparam logic [SUM_W-1:0]   SAT_LIMIT  =
    {{(SUM_W - DATA_OUT_W){1'b0}}, {DATA_OUT_W{1'b1}}};

`ifdef FIR_DEC_ROUND_EN
  localparam logic [SUM_W-1:0] ROUND_ADD = SUM_W'(1) << (SHIFT - 1);
`else
  localparam logic [SUM_W-1:0] ROUND_ADD = '0;
`endif

  logic [PRIME_W-1:0]    prime_cnt;
  logic [DEC_W-1:0]      dec_cnt;
  logic                  primed;
  logic                  keep;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      shifted;
  logic [DATA_OUT_W-1:0] scaled;
  logic                  scale_valid;
  logic [DATA_OUT_W-1:0] scale_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  // Keep decision and the scale/saturate datapath. The sum is one bit wider
  // than the input so the rounding offset can never wrap a large sample.
  always_comb begin
    primed  = (prime_cnt == PRIME_DONE);
    keep    = in_valid & primed & (dec_cnt == '0);
    sum     = {1'b0, FIR_in} + ROUND_ADD;
    shifted = sum >> SHIFT;
    scaled  = (shifted > SAT_LIMIT) ? '1 : shifted[DATA_OUT_W-1:0];
  end

  // Count accepted samples until the filter pipeline is full, then hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prime_cnt <= '0;
    end else if (in_valid && !primed) begin
      prime_cnt <= prime_cnt + 1'b1;
    end
  end

  // Decimation phase; only advances on accepted samples once primed, so the
  // very first post-prime sample lands on phase zero and is kept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dec_cnt <= '0;
    end else if (in_valid && primed) begin
      dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
    end
  end

  // Scale register: one cycle between the kept sample and its FIFO write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scale_valid <= 1'b0;
      scale_data  <= '0;
    end else begin
      scale_valid <= keep;
      if (keep) begin
        scale_data <= scaled;
      end
    end
  end

  // Sticky flag for a kept word that found the FIFO full with no pop to
  // make room; only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (scale_valid && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  fir_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_OUT_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (scale_valid),
    .pop     (pop),
    .wr_data (scale_data),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_fir_output_decimator.sv
// tb_fir_output_decimator: self-checking bench for fir_output_decimator.
// Directed table for the steady decimation pattern, hand-written sequences for
// FIFO full/overflow/drain and async reset, and a randomized run compared
// against a queue-based reference model. Honors FIR_DEC_ROUND_EN.
module tb_fir_output_decimator;

  localparam int IN_W  = 15;
  localparam int OUT_W = 8;
  localparam int SHIFT = 7;
  localparam int DEC   = 2;
  localparam int PRIME = 2;
  localparam int DEPTH = 4;

`ifdef FIR_DEC_ROUND_EN
  localparam int ROUND   = 1 << (SHIFT - 1);
  localparam int EXP_1000 = 8;
`else
  localparam int ROUND   = 0;
  localparam int EXP_1000 = 7;
`endif

  logic             clock;
  logic             reset;
  logic [IN_W-1:0]  FIR_in;
  logic             in_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       fifo_count;
  logic             overflow;

  int check_count = 0;
  int error_count = 0;

  typedef struct {
    int fir;
    bit iv;
    bit rdy;
    bit exp_valid;
    int exp_data;
    int exp_count;
  } vec_t;

  vec_t vecs[14];

  int m_q[$];
  bit m_pend_v = 1'b0;
  int m_pend   = 0;
  int m_n      = 0;
  bit m_ovf    = 1'b0;
  int m_size_before;
  bit m_pop;

  fir_output_decimator #(
    .DATA_IN_W    (IN_W),
    .DATA_OUT_W   (OUT_W),
    .SHIFT        (SHIFT),
    .DEC_FACTOR   (DEC),
    .PRIME_CYCLES (PRIME),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .FIR_in     (FIR_in),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference scaling: round or truncate, then clamp to the output range.
  function automatic int model_scale(input int x);
    int s;
    s = (x + ROUND) >> SHIFT;
    return (s > 255) ? 255 : s;
  endfunction

  // The n-th accepted sample since reset is kept once priming is done,
  // then one in every DEC.
  function automatic bit model_kept(input int n);
    return (n >= PRIME) && (((n - PRIME) % DEC) == 0);
  endfunction

  // Reference model: one-cycle scale delay, then a bounded queue.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_pend_v = 1'b0;
      m_pend   = 0;
      m_n      = 0;
      m_ovf    = 1'b0;
    end else begin
      m_size_before = m_q.size();
      m_pop = (m_size_before > 0) && out_ready;
      if (m_pop) void'(m_q.pop_front());
      if (m_pend_v) begin
        if (m_size_before < DEPTH || m_pop) m_q.push_back(m_pend);
        else m_ovf = 1'b1;
      end
      m_pend_v = in_valid && model_kept(m_n);
      m_pend   = model_scale(int'(FIR_in));
      if (in_valid) m_n++;
    end
  end

  // Safety net so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, got hang, expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_value(input string name, input int actual, input int expected);
    check_count++;
    if (actual != expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int fir, input bit iv, input bit rdy);
    FIR_in    = IN_W'(fir);
    in_valid  = iv;
    out_ready = rdy;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic checkOutput(input string name);
    check_value({name, " out_valid"}, int'(out_valid), int'(m_q.size() > 0));
    check_value({name, " fifo_count"}, int'(fifo_count), m_q.size());
    check_value({name, " overflow"}, int'(overflow), int'(m_ovf));
    if (m_q.size() > 0) check_value({name, " out_data"}, int'(out_data), m_q[0]);
  endtask

  task automatic doReset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    FIR_in    = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Drain the FIFO one word per cycle, checking the order against exp.
  task automatic drainExpect(input string name, input int exp[4]);
    for (int k = 0; k < 4; k++) begin
      check_value({name, " drain valid"}, int'(out_valid), 1);
      check_value({name, " drain data"}, int'(out_data), exp[k]);
      applyStimulus(0, 1'b0, 1'b1);
    end
    check_value({name, " drained valid"}, int'(out_valid), 0);
    check_value({name, " drained count"}, int'(fifo_count), 0);
  endtask

  initial begin
    int exp4[4];

    for (int r = 0; r < 14; r++) begin
      vecs[r].fir       = (r < 10) ? 1000 : 32767;
      vecs[r].iv        = 1'b1;
      vecs[r].rdy       = 1'b1;
      vecs[r].exp_valid = (r >= 3) && (r % 2 == 1);
      vecs[r].exp_data  = (r < 10) ? EXP_1000 : 255;
      vecs[r].exp_count = vecs[r].exp_valid ? 1 : 0;
    end

    reset     = 1'b0;
    FIR_in    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("[TB] reset held with in_valid active");
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1000, 1'b1, 1'b1);
      check_value("reset out_valid", int'(out_valid), 0);
      check_value("reset fifo_count", int'(fifo_count), 0);
      check_value("reset overflow", int'(overflow), 0);
      check_value("reset out_data", int'(out_data), 0);
    end

    $display("[TB] directed decimation table");
    reset = 1'b1;
    for (int r = 0; r < 14; r++) begin
      applyStimulus(vecs[r].fir, vecs[r].iv, vecs[r].rdy);
      check_value($sformatf("table[%0d] out_valid", r), int'(out_valid), int'(vecs[r].exp_valid));
      check_value($sformatf("table[%0d] fifo_count", r), int'(fifo_count), vecs[r].exp_count);
      check_value($sformatf("table[%0d] overflow", r), int'(overflow), 0);
      if (vecs[r].exp_valid)
        check_value($sformatf("table[%0d] out_data", r), int'(out_data), vecs[r].exp_data);
    end

    $display("[TB] fill past full with consumer stalled");
    doReset();
    for (int n = 0; n < 22; n++) begin
      applyStimulus(n * 256, 1'b1, 1'b0);
      checkOutput("fill");
    end
    check_value("full fifo_count", int'(fifo_count), 4);
    check_value("full overflow", int'(overflow), 1);
    exp4 = '{4, 8, 12, 16};
    drainExpect("overflow", exp4);
    check_value("post-drain overflow sticky", int'(overflow), 1);

    $display("[TB] push and pop while full");
    doReset();
    for (int n = 0; n < 11; n++) begin
      applyStimulus(n * 256, 1'b1, 1'b0);
      checkOutput("prefill");
    end
    check_value("prefill fifo_count", int'(fifo_count), 4);
    check_value("prefill overflow", int'(overflow), 0);
    applyStimulus(0, 1'b0, 1'b1);
    check_value("push+pop fifo_count", int'(fifo_count), 4);
    check_value("push+pop overflow", int'(overflow), 0);
    exp4 = '{8, 12, 16, 20};
    drainExpect("push+pop", exp4);

    $display("[TB] idle cycles and async reset mid-stream");
    doReset();
    for (int c = 0; c < 20; c++) begin
      applyStimulus($urandom_range(0, 32767), (c % 2) == 0, 1'b0);
      checkOutput("toggle");
    end
    check_value("toggle pre-reset out_valid", int'(out_valid), 1);
    #2 reset = 1'b0;
    #1;
    check_value("async reset out_valid", int'(out_valid), 0);
    check_value("async reset fifo_count", int'(fifo_count), 0);
    check_value("async reset overflow", int'(overflow), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1000, 1'b1, 1'b1);
      check_value("re-prime out_valid", int'(out_valid), int'(c >= 3 && (c % 2) == 1));
      checkOutput("re-prime");
    end

    $display("[TB] randomized run against reference model");
    doReset();
    for (int i = 0; i < 500; i++) begin
      int fir;
      bit iv;
      bit rdy;
      if (i == 250) doReset();
      fir = ($urandom_range(0, 3) == 0) ? $urandom_range(30000, 32767) : $urandom_range(0, 32767);
      iv  = $urandom_range(0, 3) != 0;
      rdy = ((i % 100) < 40) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      applyStimulus(fir, iv, rdy);
      checkOutput("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
